// File: rtl/test_seq_ctrl.sv
// test_seq_ctrl: test-sequence controller sitting on the control-flit chain.
//   Consumes register writes addressed to LMID, answers counter/state reads by
//   rewriting the request header into a response, and forwards every other flit
//   with one cycle of latency. A small FSM drives the test generator enable and
//   the statistics window signals.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cin_tsc_data/_wr      control flit in from DMA
//   cout_tsc_ready        ready back to DMA (mirrors cin_tsc_ready)
//   cout_tsc_data/_wr     control flit out to next module
//   cin_tsc_ready         downstream ready
//   gen_pkt_sent          one pulse per generated test packet
//   tsc2gen_en            generator enable
//   tsc2scm_sent_start    statistics window open
//   tsc2scm_sent_end      generation finished
//   tsc2scm_stat_reset    one-cycle statistics clear
//   tsc_busy              sequence in progress
module test_seq_ctrl #(
  parameter logic [7:0]  LMID      = 8'd8,
  parameter logic [31:0] DRAIN_DEF = 32'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] cin_tsc_data,
  input  logic         cin_tsc_data_wr,
  output logic         cout_tsc_ready,
  output logic [133:0] cout_tsc_data,
  output logic         cout_tsc_data_wr,
  input  logic         cin_tsc_ready,
  input  logic         gen_pkt_sent,
  output logic         tsc2gen_en,
  output logic         tsc2scm_sent_start,
  output logic         tsc2scm_sent_end,
  output logic         tsc2scm_stat_reset,
  output logic         tsc_busy
);

  localparam logic [31:0] ADDR_CTRL   = 32'h8000_0000;
  localparam logic [31:0] ADDR_TARGET = 32'h8000_0001;
  localparam logic [31:0] ADDR_DRAIN  = 32'h8000_0002;
  localparam logic [31:0] ADDR_CNT    = 32'h8000_0008;
  localparam logic [31:0] ADDR_STATE  = 32'h8000_0009;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   sent_cnt;
  logic [31:0]   drain_cnt;
  logic [31:0]   pkt_target;
  logic [31:0]   drain_cycles;
  logic          drop_trl;
  logic [133:0]  data_p0;
  logic          vld_p0;

  logic          is_hdr, is_trl, to_me;
  logic [31:0]   addr, wdata, rd_val;
  logic          wr_hit, rd_hit, trl_drop_now;
  logic          start, abort, hit_target;
  logic [133:0]  rd_resp;

  // Flit decode
  always_comb begin
    is_hdr       = cin_tsc_data_wr && (cin_tsc_data[133:132] == 2'b01);
    is_trl       = cin_tsc_data_wr && (cin_tsc_data[133:132] == 2'b10);
    to_me        = (cin_tsc_data[103:96] == LMID);
    addr         = cin_tsc_data[95:64];
    wdata        = cin_tsc_data[31:0];
    wr_hit       = is_hdr && (cin_tsc_data[126:124] == 3'b010) && to_me;
    rd_hit       = is_hdr && (cin_tsc_data[126:124] == 3'b001) && to_me &&
                   ((addr == ADDR_CNT) || (addr == ADDR_STATE));
    // The trailer belonging to a consumed write header is swallowed too.
    trl_drop_now = is_trl && drop_trl;
    start        = wr_hit && (addr == ADDR_CTRL) && wdata[0];
    abort        = wr_hit && (addr == ADDR_CTRL) && wdata[1];
    rd_val       = (addr == ADDR_CNT) ? sent_cnt : {29'd0, state};
    // Response: op nibble becomes 1011, src/dst bytes swapped, low word = value.
    rd_resp      = {cin_tsc_data[133:128], 4'b1011, cin_tsc_data[123:112],
                    cin_tsc_data[103:96], cin_tsc_data[111:104],
                    cin_tsc_data[95:32], rd_val};
    // 33-bit compare so a saturated count never aliases onto a target of 0.
    hit_target   = (({1'b0, sent_cnt} + 33'd1) == {1'b0, pkt_target});
  end

  // Stage p0: forwarding register
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0  <= '0;
      vld_p0   <= 1'b0;
      drop_trl <= 1'b0;
    end else begin
      if (wr_hit)      drop_trl <= 1'b1;
      else if (is_trl) drop_trl <= 1'b0;
      if (!cin_tsc_data_wr || wr_hit || trl_drop_now) begin
        data_p0 <= '0;
        vld_p0  <= 1'b0;
      end else if (rd_hit) begin
        data_p0 <= rd_resp;
        vld_p0  <= 1'b1;
      end else begin
        data_p0 <= cin_tsc_data;
        vld_p0  <= 1'b1;
      end
    end
  end

  assign cout_tsc_data    = data_p0;
  assign cout_tsc_data_wr = vld_p0;
  assign cout_tsc_ready   = cin_tsc_ready;

  // Configuration registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_target   <= '0;
      drain_cycles <= DRAIN_DEF;
      sent_cnt     <= '0;
      drain_cnt    <= '0;
    end else begin
      if (wr_hit && (addr == ADDR_TARGET)) pkt_target   <= wdata;
      if (wr_hit && (addr == ADDR_DRAIN))  drain_cycles <= wdata;
      if (((state == S_IDLE) || (state == S_DONE)) && start)
        sent_cnt <= '0;
      else if ((state == S_RUN) && gen_pkt_sent && (sent_cnt != 32'hFFFF_FFFF))
        sent_cnt <= sent_cnt + 32'd1;
      if ((state == S_DRAIN) && (state_nx == S_DRAIN))
        drain_cnt <= drain_cnt + 32'd1;
      else
        drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx           = state;
    tsc2gen_en         = 1'b0;
    tsc2scm_sent_start = 1'b0;
    tsc2scm_sent_end   = 1'b0;
    tsc2scm_stat_reset = 1'b0;
    tsc_busy           = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        tsc2scm_sent_end = (state == S_DONE);
        if (start) state_nx = S_CLR;
      end
      S_CLR: begin
        tsc2scm_stat_reset = 1'b1;
        tsc_busy           = 1'b1;
        state_nx           = (pkt_target == 32'd0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        tsc2gen_en         = 1'b1;
        tsc2scm_sent_start = 1'b1;
        tsc_busy           = 1'b1;
        if (abort || (gen_pkt_sent && hit_target)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        tsc2scm_sent_start = 1'b1;
        tsc2scm_sent_end   = 1'b1;
        tsc_busy           = 1'b1;
        // >= keeps a shrunken drain_cycles from stranding the counter.
        if (drain_cnt >= drain_cycles) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
